frame_strobe_sequencer: RTL and testbench

Upstream feeder for a column of tile configuration memories. It takes a 32-bit configuration word stream over a valid/ready handshake and decodes header and data word pairs. For each pair it drives the column-wide FrameData bus and a one-hot FrameStrobe pulse that writes one frame into the tile frame latches. The strobe is framed by guaranteed setup and hold cycles so the level-sensitive latches capture stable data.

---
 rtl/frame_strobe_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_frame_strobe_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_strobe_sequencer.sv
// Configuration frame sequencer: decodes header/data word pairs from a stream and
// writes one frame per pair into the column latches with setup, strobe and hold cycles.
module frame_strobe_sequencer #(
    parameter int          MaxFramesPerCol = 20,
    parameter int          FrameBitsPerRow = 32,
    parameter int          StrobeCycles    = 2,
    parameter logic [15:0] SyncMarker      = 16'hFAB0
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       err_clear,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       err_hdr,
    output logic                       err_idx,
    output logic [15:0]                frames_written
);

    localparam logic [7:0]                 IDX_LIMIT   = 8'(MaxFramesPerCol);
    localparam logic [3:0]                 STROBE_LAST = 4'(StrobeCycles - 1);
    localparam logic [MaxFramesPerCol-1:0] STROBE_ONE  = {{(MaxFramesPerCol-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_SETUP     = 3'd2,
        ST_STROBE    = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    state_t                     state_r, state_s;
    logic [7:0]                 idx_r, idx_s;
    logic                       discard_r, discard_s;
    logic [3:0]                 strobe_cnt_r, strobe_cnt_s;
    logic [FrameBitsPerRow-1:0] data_r, data_s;
    logic [MaxFramesPerCol-1:0] strobe_r, strobe_s;
    logic                       ready_r, ready_s;
    logic                       busy_r, busy_s;
    logic                       err_hdr_r, err_hdr_s;
    logic                       err_idx_r, err_idx_s;
    logic [15:0]                frames_r, frames_s;
    logic                       xfer_s;
    logic                       hdr_set_s;
    logic                       idx_set_s;

    // Next-state decode plus next values of every registered output.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        discard_s    = discard_r;
        data_s       = data_r;
        strobe_cnt_s = 4'd0;
        hdr_set_s    = 1'b0;
        idx_set_s    = 1'b0;
        xfer_s       = s_valid & ready_r;

        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    if (s_data[31:16] != SyncMarker) begin
                        hdr_set_s = 1'b1;
                    end else if (s_data[7:0] >= IDX_LIMIT) begin
                        idx_set_s = 1'b1;
                        discard_s = 1'b1;
                        state_s   = ST_WAIT_DATA;
                    end else begin
                        idx_s     = s_data[7:0];
                        discard_s = 1'b0;
                        state_s   = ST_WAIT_DATA;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (xfer_s) begin
                    if (discard_r) begin
                        discard_s = 1'b0;
                        state_s   = ST_IDLE;
                    end else begin
                        data_s  = s_data;
                        state_s = ST_SETUP;
                    end
                end else begin
                    state_s = ST_WAIT_DATA;
                end
            end
            ST_SETUP: begin
                state_s = ST_STROBE;
            end
            ST_STROBE: begin
                if (strobe_cnt_r == STROBE_LAST) begin
                    state_s = ST_HOLD;
                end else begin
                    strobe_cnt_s = strobe_cnt_r + 4'd1;
                end
            end
            ST_HOLD: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                discard_s = 1'b0;
            end
        endcase

        // Outputs are registered from the next state so they never glitch.
        ready_s = (state_s == ST_IDLE) || (state_s == ST_WAIT_DATA);
        busy_s  = (state_s != ST_IDLE);

        if (state_s == ST_STROBE) begin
            strobe_s = STROBE_ONE << idx_s;
        end else begin
            strobe_s = {MaxFramesPerCol{1'b0}};
        end

        if (state_s == ST_HOLD) begin
            frames_s = frames_r + 16'd1;
        end else begin
            frames_s = frames_r;
        end

        if (hdr_set_s) begin
            err_hdr_s = 1'b1;
        end else if (err_clear) begin
            err_hdr_s = 1'b0;
        end else begin
            err_hdr_s = err_hdr_r;
        end

        if (idx_set_s) begin
            err_idx_s = 1'b1;
        end else if (err_clear) begin
            err_idx_s = 1'b0;
        end else begin
            err_idx_s = err_idx_r;
        end
    end

    // State and output registers; reset clears every output at once.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            idx_r        <= 8'd0;
            discard_r    <= 1'b0;
            strobe_cnt_r <= 4'd0;
            data_r       <= {FrameBitsPerRow{1'b0}};
            strobe_r     <= {MaxFramesPerCol{1'b0}};
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            err_hdr_r    <= 1'b0;
            err_idx_r    <= 1'b0;
            frames_r     <= 16'd0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            discard_r    <= discard_s;
            strobe_cnt_r <= strobe_cnt_s;
            data_r       <= data_s;
            strobe_r     <= strobe_s;
            ready_r      <= ready_s;
            busy_r       <= busy_s;
            err_hdr_r    <= err_hdr_s;
            err_idx_r    <= err_idx_s;
            frames_r     <= frames_s;
        end
    end

    assign s_ready        = ready_r;
    assign FrameData      = data_r;
    assign FrameStrobe    = strobe_r;
    assign busy           = busy_r;
    assign err_hdr        = err_hdr_r;
    assign err_idx        = err_idx_r;
    assign frames_written = frames_r;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Bench for frame_strobe_sequencer: directed vector table, reset corner cases and a
// randomized stream checked cycle by cycle against a timeline reference model.
module tb_frame_strobe_sequencer;

    localparam int SC = 2;
    localparam int NF = 20;

    logic        CLK;
    logic        resetn;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        err_clear;
    logic [31:0] FrameData;
    logic [19:0] FrameStrobe;
    logic        busy;
    logic        err_hdr;
    logic        err_idx;
    logic [15:0] frames_written;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] dat;
        bit          send_dat;
        logic [19:0] exp_strobe;
        logic [31:0] exp_data;
        logic [15:0] exp_frames;
        bit          exp_err_hdr;
        bit          exp_err_idx;
        bit          clr;
    } vec_t;

    vec_t vecs[7];
    vec_t after_rst;

    frame_strobe_sequencer #(
        .MaxFramesPerCol(NF),
        .FrameBitsPerRow(32),
        .StrobeCycles(SC),
        .SyncMarker(16'hFAB0)
    ) dut (
        .CLK(CLK),
        .resetn(resetn),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .err_clear(err_clear),
        .FrameData(FrameData),
        .FrameStrobe(FrameStrobe),
        .busy(busy),
        .err_hdr(err_hdr),
        .err_idx(err_idx),
        .frames_written(frames_written)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        s_valid   = 1'b0;
        err_clear = 1'b0;
        s_data    = 32'd0;
        @(negedge CLK);
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
    endtask

    // Offer one word until accepted; returns at the negedge after the transfer.
    task automatic send_word(input logic [31:0] w);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("send_ready", 32'(s_ready), 32'd1);
        @(negedge CLK);
        s_valid = 1'b0;
    endtask

    task automatic apply_entry(input vec_t v);
        send_word(v.hdr);
        if (v.send_dat) begin
            send_word(v.dat);
        end
        if (v.exp_strobe != 20'd0) begin
            chk("setup_data", FrameData, v.exp_data);
            chk("setup_strobe", 32'(FrameStrobe), 32'd0);
            chk("setup_ready", 32'(s_ready), 32'd0);
            for (int k = 0; k < SC; k++) begin
                @(negedge CLK);
                chk("strobe", 32'(FrameStrobe), 32'(v.exp_strobe));
                chk("strobe_data", FrameData, v.exp_data);
                chk("strobe_ready", 32'(s_ready), 32'd0);
            end
            @(negedge CLK);
            chk("hold_strobe", 32'(FrameStrobe), 32'd0);
            chk("hold_ready", 32'(s_ready), 32'd0);
            chk("hold_frames", 32'(frames_written), 32'(v.exp_frames));
            @(negedge CLK);
        end else begin
            for (int k = 0; k < SC + 3; k++) begin
                chk("no_strobe", 32'(FrameStrobe), 32'd0);
                @(negedge CLK);
            end
        end
        chk("idle_ready", 32'(s_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("data", FrameData, v.exp_data);
        chk("frames", 32'(frames_written), 32'(v.exp_frames));
        chk("err_hdr", 32'(err_hdr), 32'(v.exp_err_hdr));
        chk("err_idx", 32'(err_idx), 32'(v.exp_err_idx));
        if (v.clr) begin
            err_clear = 1'b1;
            @(negedge CLK);
            err_clear = 1'b0;
            chk("clr_err_hdr", 32'(err_hdr), 32'd0);
            chk("clr_err_idx", 32'(err_idx), 32'd0);
        end
    endtask

    // Timeline model: each accepted data word schedules its strobe window, the
    // counter bump and the next idle cycle as plain cycle offsets.
    task automatic run_model(input bit mixed, input int pairs);
        logic [31:0] q[$];
        logic [31:0] w;
        logic [31:0] mdata;
        logic [19:0] mstr;
        logic [19:0] exp_str;
        logic [15:0] mframes;
        logic [7:0]  pidx;
        int          c, idle_at, s0, s1, inc_at, r;
        bit          pend, disc, mhdr, midx, hset, iset, mready, mbusy;

        for (int i = 0; i < pairs; i++) begin
            r = mixed ? int'($urandom_range(0, 9)) : 9;
            case (r)
                0:       q.push_back({16'h1234, 16'($urandom)});
                1:       q.push_back({16'hFAB0, 8'($urandom), 8'($urandom_range(20, 255))});
                default: q.push_back({16'hFAB0, 8'($urandom), 8'($urandom_range(0, NF - 1))});
            endcase
            q.push_back($urandom);
        end

        c = 0; idle_at = 0; s0 = 1; s1 = 0; inc_at = -1;
        pend = 1'b0; disc = 1'b0; mhdr = 1'b0; midx = 1'b0;
        mdata = 32'd0; mstr = 20'd0; mframes = 16'd0; pidx = 8'd0;

        while ((q.size() > 0 || pend || c <= idle_at) && c < 5000) begin
            if (c == inc_at) begin
                mframes = mframes + 16'd1;
            end
            exp_str = (c >= s0 && c <= s1) ? mstr : 20'd0;
            mready  = (c >= idle_at);
            mbusy   = pend || (c < idle_at);
            chk("m_ready", 32'(s_ready), 32'(mready));
            chk("m_busy", 32'(busy), 32'(mbusy));
            chk("m_strobe", 32'(FrameStrobe), 32'(exp_str));
            chk("m_onehot", 32'($countones(FrameStrobe) <= 1), 32'd1);
            chk("m_data", FrameData, mdata);
            chk("m_frames", 32'(frames_written), 32'(mframes));
            chk("m_err_hdr", 32'(err_hdr), 32'(mhdr));
            chk("m_err_idx", 32'(err_idx), 32'(midx));

            s_valid   = (q.size() > 0) && ($urandom_range(0, 99) < 60);
            s_data    = (q.size() > 0) ? q[0] : $urandom;
            err_clear = mixed && ($urandom_range(0, 9) == 0);

            hset = 1'b0;
            iset = 1'b0;
            if (s_valid && mready) begin
                w = q.pop_front();
                if (!pend) begin
                    if (w[31:16] != 16'hFAB0) begin
                        hset = 1'b1;
                    end else begin
                        pend = 1'b1;
                        pidx = w[7:0];
                        disc = (w[7:0] >= 8'd20);
                        iset = disc;
                    end
                end else begin
                    pend = 1'b0;
                    if (!disc) begin
                        mdata   = w;
                        mstr    = 20'd1 << pidx;
                        s0      = c + 2;
                        s1      = c + 1 + SC;
                        inc_at  = c + 2 + SC;
                        idle_at = c + 3 + SC;
                    end
                end
            end
            mhdr = hset ? 1'b1 : (err_clear ? 1'b0 : mhdr);
            midx = iset ? 1'b1 : (err_clear ? 1'b0 : midx);

            @(negedge CLK);
            c++;
        end
        s_valid   = 1'b0;
        err_clear = 1'b0;
        chk("model_drain", 32'(c < 5000), 32'd1);
    endtask

    initial begin
        vecs[0] = '{32'hFAB0_0005, 32'hDEAD_BEEF, 1'b1, 20'h00020, 32'hDEAD_BEEF, 16'd1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h1234_0003, 32'h0000_0000, 1'b0, 20'h00000, 32'hDEAD_BEEF, 16'd1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'hFAB0_0013, 32'h0000_00FF, 1'b1, 20'h80000, 32'h0000_00FF, 16'd2, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{32'hFAB0_0014, 32'hAAAA_AAAA, 1'b1, 20'h00000, 32'h0000_00FF, 16'd2, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'hFAB0_FF00, 32'h1234_5678, 1'b1, 20'h00001, 32'h1234_5678, 16'd3, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'hFAB0_00FF, 32'h5555_5555, 1'b1, 20'h00000, 32'h1234_5678, 16'd3, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'hFAB0_000A, 32'hCAFE_F00D, 1'b1, 20'h00400, 32'hCAFE_F00D, 16'd4, 1'b0, 1'b1, 1'b1};
        after_rst = '{32'hFAB0_0011, 32'h1357_9BDF, 1'b1, 20'h20000, 32'h1357_9BDF, 16'd1, 1'b0, 1'b0, 1'b0};

        resetn    = 1'b0;
        s_valid   = 1'b0;
        err_clear = 1'b0;
        s_data    = 32'd0;
        #1;
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_strobe", 32'(FrameStrobe), 32'd0);
        chk("rst_data", FrameData, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", 32'(frames_written), 32'd0);
        chk("rst_errs", 32'({err_hdr, err_idx}), 32'd0);
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        chk("post_rst_ready", 32'(s_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            apply_entry(vecs[i]);
        end

        // Error set and clear in the same cycle: the set takes priority.
        err_clear = 1'b1;
        send_word(32'h1234_0000);
        err_clear = 1'b0;
        chk("set_wins", 32'(err_hdr), 32'd1);

        // Reset asserted in the middle of a strobe.
        send_word(32'hFAB0_0007);
        send_word(32'h0BAD_F00D);
        @(negedge CLK);
        chk("mid_strobe", 32'(FrameStrobe), 32'h00080);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_strobe", 32'(FrameStrobe), 32'd0);
        chk("async_data", FrameData, 32'd0);
        chk("async_ready", 32'(s_ready), 32'd0);
        chk("async_frames", 32'(frames_written), 32'd0);
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        chk("rerst_ready", 32'(s_ready), 32'd1);
        chk("rerst_busy", 32'(busy), 32'd0);
        apply_entry(after_rst);

        do_reset();
        run_model(1'b0, 50);
        chk("frames_50", 32'(frames_written), 32'd50);

        do_reset();
        run_model(1'b1, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
